// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared constants, state encoding and coefficient index to bank/address mapping
package fir_ctrl_pkg;
  localparam int NUM_COEFF = 12;
  localparam int POS_TAPS = 7;
  localparam int NEG_TAPS = 5;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {sIdle, sLoad, sWait, sRead} state_e;
  typedef struct packed {
    logic pos;
    logic [ADDR_W-1:0] addr;
  } map_t;
  // odd idx fill the positive bank from 1, even idx the negative bank; the last word closes the positive bank
  function automatic map_t idx_map(input logic [ADDR_W-1:0] idx);
    map_t m;
    m.pos = (idx == ADDR_W'(NUM_COEFF)) | idx[0];
    m.addr = (idx == ADDR_W'(NUM_COEFF)) ? ADDR_W'(POS_TAPS) : {1'b0, idx[3:1]} + {3'b0, idx[0]};
    return m;
  endfunction
endpackage

// File: rtl/fir_coeff_addr_map.sv
// fir_coeff_addr_map: combinational coefficient index to {bank, address}
module fir_coeff_addr_map
  import fir_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] idx,
  output logic              pos_bank,
  output logic [ADDR_W-1:0] addr
);
  map_t m;
  always_comb begin
    m = idx_map(idx);
    pos_bank = m.pos;
    addr = m.addr;
  end
endmodule

// File: rtl/fir_coeff_seq_ctrl.sv
// fir_coeff_seq_ctrl: loads FIR coefficients into the pos/neg tap banks, then sweeps both banks per sample
module fir_coeff_seq_ctrl
  import fir_ctrl_pkg::*;
(
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iEnSample_600k,
  input  logic              iLoadReq,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam_pos,
  output logic [ADDR_W-1:0] oAddrRam_neg,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic [5:0]        oNumOfCoeff,
  output logic              oCoeffLoaded,
  output logic              oSampleMiss
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, step_q, step_d, apos_q, apos_d, aneg_q, aneg_d, map_addr;
  logic [DATA_W-1:0] wrdt_q, wrdt_d;
  logic [5:0] num_q, num_d;
  logic pend_q, pend_d, ready_q, ready_d, upd_q, upd_d, csn_q, csn_d, wrn_q, wrn_d;
  logic loaded_q, loaded_d, miss_q, miss_d, map_pos, go_load;
  fir_coeff_addr_map u_map (.idx(idx_q), .pos_bank(map_pos), .addr(map_addr));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    step_d = step_q;
    pend_d = pend_q;
    ready_d = ready_q;
    upd_d = upd_q;
    csn_d = 1'b1;
    wrn_d = 1'b1;
    apos_d = '0;
    aneg_d = '0;
    wrdt_d = wrdt_q;
    num_d = num_q;
    loaded_d = loaded_q;
    miss_d = 1'b0;
    go_load = 1'b0;
    case (state_q)
      sIdle: begin
        miss_d = iEnSample_600k;
        go_load = iLoadReq;
      end
      sLoad: begin
        miss_d = iEnSample_600k;
        if (iCoeffValid && ready_q) begin
          csn_d = 1'b0;
          wrn_d = 1'b0;
          apos_d = map_pos ? map_addr : '0;
          aneg_d = map_pos ? '0 : map_addr;
          wrdt_d = iCoeffData;
          num_d = {2'b0, idx_q};
          idx_d = idx_q + 1'b1;
          if (idx_q == ADDR_W'(NUM_COEFF)) begin
            state_d = sWait;
            ready_d = 1'b0;
            upd_d = 1'b0;
            loaded_d = 1'b1;
          end
        end
      end
      sWait: begin
        go_load = iLoadReq;
        miss_d = iLoadReq & iEnSample_600k;
        if (!iLoadReq && iEnSample_600k) begin
          state_d = sRead;
          step_d = 4'd1;
          pend_d = 1'b0;
        end
      end
      default: begin
        miss_d = iEnSample_600k;
        pend_d = pend_q | iLoadReq;
        if (step_q == ADDR_W'(POS_TAPS)) begin
          state_d = sWait;
          go_load = pend_q | iLoadReq;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    endcase
    if (go_load) begin
      state_d = sLoad;
      idx_d = 4'd1;
      ready_d = 1'b1;
      upd_d = 1'b1;
      loaded_d = 1'b0;
      num_d = '0;
      pend_d = 1'b0;
    end
    if (state_d == sRead) begin
      csn_d = 1'b0;
      apos_d = step_d;
      aneg_d = (step_d <= ADDR_W'(NEG_TAPS)) ? step_d : '0;
    end
  end
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= sIdle;
      idx_q <= '0;
      step_q <= '0;
      pend_q <= 1'b0;
      ready_q <= 1'b0;
      upd_q <= 1'b0;
      csn_q <= 1'b1;
      wrn_q <= 1'b1;
      apos_q <= '0;
      aneg_q <= '0;
      wrdt_q <= '0;
      num_q <= '0;
      loaded_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      step_q <= step_d;
      pend_q <= pend_d;
      ready_q <= ready_d;
      upd_q <= upd_d;
      csn_q <= csn_d;
      wrn_q <= wrn_d;
      apos_q <= apos_d;
      aneg_q <= aneg_d;
      wrdt_q <= wrdt_d;
      num_q <= num_d;
      loaded_q <= loaded_d;
      miss_q <= miss_d;
    end
  end
  assign oCoeffReady = ready_q;
  assign oCoeffiUpdateFlag = upd_q;
  assign oCsnRam = csn_q;
  assign oWrnRam = wrn_q;
  assign oAddrRam_pos = apos_q;
  assign oAddrRam_neg = aneg_q;
  assign oWrDtRam = wrdt_q;
  assign oNumOfCoeff = num_q;
  assign oCoeffLoaded = loaded_q;
  assign oSampleMiss = miss_q;
endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// tb_fir_coeff_seq_ctrl: directed table-driven checks of load, read sweep, collisions and reset
module tb_fir_coeff_seq_ctrl;
  logic clk = 1'b0, rsn = 1'b0, en = 1'b0, req = 1'b0, valid = 1'b0;
  logic [15:0] data = '0;
  logic ready, upd, csn, wrn, loaded, miss;
  logic [3:0] apos, aneg;
  logic [15:0] wrdt;
  logic [5:0] num;
  int total = 0, passed = 0;
  typedef struct {
    logic [15:0] d;
    logic [3:0] pa;
    logic [3:0] na;
  } vec_t;
  vec_t tbl[12];

  fir_coeff_seq_ctrl dut (
    .iClk_12M(clk), .iRsn(rsn), .iEnSample_600k(en), .iLoadReq(req),
    .iCoeffValid(valid), .iCoeffData(data), .oCoeffReady(ready),
    .oCoeffiUpdateFlag(upd), .oCsnRam(csn), .oWrnRam(wrn),
    .oAddrRam_pos(apos), .oAddrRam_neg(aneg), .oWrDtRam(wrdt),
    .oNumOfCoeff(num), .oCoeffLoaded(loaded), .oSampleMiss(miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_csn", csn, 1);
    chk("rst_wrn", wrn, 1);
    chk("rst_apos", apos, 0);
    chk("rst_aneg", aneg, 0);
    chk("rst_wrdt", wrdt, 0);
    chk("rst_num", num, 0);
    chk("rst_ready", ready, 0);
    chk("rst_upd", upd, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_miss", miss, 0);
  endtask

  task automatic load_req();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("entry_ready", ready, 1);
    chk("entry_upd", upd, 1);
    chk("entry_loaded", loaded, 0);
    chk("entry_csn", csn, 1);
  endtask

  task automatic stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          valid = 1'b0;
          tick();
          chk("gap_csn", csn, 1);
        end
      end
      valid = 1'b1;
      data = tbl[i].d;
      tick();
      valid = 1'b0;
      chk("wr_csn", csn, 0);
      chk("wr_wrn", wrn, 0);
      chk("wr_apos", apos, tbl[i].pa);
      chk("wr_aneg", aneg, tbl[i].na);
      chk("wr_data", wrdt, tbl[i].d);
      chk("wr_num", num, i + 1);
      if (i == 11) chk("last_ready", ready, 0);
    end
    if (n == 12) begin
      tick();
      chk("done_upd", upd, 0);
      chk("done_loaded", loaded, 1);
      chk("done_ready", ready, 0);
      chk("done_csn", csn, 1);
      chk("done_num", num, 12);
    end
  endtask

  task automatic sweep(input bit req_mid);
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      chk("rd_csn", csn, 0);
      chk("rd_wrn", wrn, 1);
      chk("rd_apos", apos, s);
      chk("rd_aneg", aneg, (s <= 5) ? s : 0);
      chk("rd_miss", miss, 0);
      chk("rd_num", num, 12);
      req = req_mid && (s == 3);
      tick();
      req = 1'b0;
    end
    chk("rd_end_csn", csn, 1);
    chk("rd_end_apos", apos, 0);
    chk("rd_end_aneg", aneg, 0);
    chk("rd_end_ready", ready, req_mid);
    chk("rd_end_upd", upd, req_mid);
    chk("rd_end_loaded", loaded, !req_mid);
    if (!req_mid) begin
      for (int k = 0; k < 12; k++) begin
        tick();
        chk("idle_csn", csn, 1);
        chk("idle_miss", miss, 0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'h0003, 4'd1, 4'd0};
    tbl[1] = '{16'h0006, 4'd0, 4'd1};
    tbl[2] = '{16'h0007, 4'd2, 4'd0};
    tbl[3] = '{16'h000B, 4'd0, 4'd2};
    tbl[4] = '{16'h000D, 4'd3, 4'd0};
    tbl[5] = '{16'h0013, 4'd0, 4'd3};
    tbl[6] = '{16'h0018, 4'd4, 4'd0};
    tbl[7] = '{16'h0025, 4'd0, 4'd4};
    tbl[8] = '{16'h0030, 4'd5, 4'd0};
    tbl[9] = '{16'h0066, 4'd0, 4'd5};
    tbl[10] = '{16'h00CE, 4'd6, 4'd0};
    tbl[11] = '{16'h01F4, 4'd7, 4'd0};
    #12;
    chk_reset();
    rsn = 1'b1;
    tick();
    tick();
    chk_reset();
    load_req();
    stream(12, 1'b0);
    sweep(1'b0);
    sweep(1'b0);
    load_req();
    stream(12, 1'b1);
    sweep(1'b0);
    sweep(1'b1);
    stream(12, 1'b0);
    req = 1'b1;
    en = 1'b1;
    tick();
    req = 1'b0;
    en = 1'b0;
    chk("coll_miss", miss, 1);
    chk("coll_ready", ready, 1);
    chk("coll_upd", upd, 1);
    chk("coll_csn", csn, 1);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("load_strobe_miss", miss, 1);
    chk("load_strobe_csn", csn, 1);
    tick();
    chk("miss_once", miss, 0);
    stream(12, 1'b1);
    load_req();
    stream(6, 1'b0);
    rsn = 1'b0;
    #1;
    chk_reset();
    tick();
    rsn = 1'b1;
    tick();
    chk_reset();
    load_req();
    stream(12, 1'b0);
    sweep(1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
